// File: rtl/rv32v_types_pkg.sv
// -----------------------------------------------------------------------------
// rv32v_types_pkg
// Shared widths and types for the rv32v vector pipeline memory stage.
//   word_t       : 32-bit data/address word
//   woffset_t    : destination element offset carried down the pipe
//   vl_t/vtype_t : vector length and vector type CSR images
//   mem_state_t  : memory-stage sequencer states
//   sew_t        : decoded selected element width
//   decode_sew() : maps vtype[5:3] onto sew_t (reserved codes act as 32 bit)
// -----------------------------------------------------------------------------
package rv32v_types_pkg;

    localparam int WORD_W    = 32;
    localparam int WOFFSET_W = 5;
    localparam int VL_W      = 32;
    localparam int VTYPE_W   = 32;

    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [WOFFSET_W-1:0] woffset_t;
    typedef logic [VL_W-1:0]      vl_t;
    typedef logic [VTYPE_W-1:0]   vtype_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ELEM1 = 2'd1,
        DONE  = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2
    } sew_t;

    function automatic sew_t decode_sew(input logic [2:0] vsew);
        sew_t s;
        case (vsew)
            3'b000:  s = SEW8;
            3'b001:  s = SEW16;
            default: s = SEW32;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/rv32v_memory_stage_if.sv
// -----------------------------------------------------------------------------
// Pipeline interfaces around the vector memory stage.
//   rv32v_hazard_unit_if      : stall_mem/flush_mem in, mem_busy out
//                               (modports: memory, hazard)
//   rv32v_execute_memory_if   : execute/memory latch contents
//                               (modports: memory = consumer, execute = producer)
//   rv32v_memory_writeback_if : memory/writeback latch contents
//                               (modports: memory = producer, writeback = consumer)
// -----------------------------------------------------------------------------
interface rv32v_hazard_unit_if;
    import rv32v_types_pkg::*;

    logic stall_mem;
    logic flush_mem;
    logic mem_busy;

    modport memory (
        input  stall_mem, flush_mem,
        output mem_busy
    );

    modport hazard (
        output stall_mem, flush_mem,
        input  mem_busy
    );
endinterface

interface rv32v_execute_memory_if;
    import rv32v_types_pkg::*;

    logic     load;
    logic     store;
    logic     wen0;
    logic     wen1;
    logic     config_type;
    word_t    aluresult0;
    word_t    aluresult1;
    word_t    storedata0;
    word_t    storedata1;
    woffset_t woffset0;
    woffset_t woffset1;
    vl_t      vl;
    vtype_t   vtype;

    modport memory (
        input load, store, wen0, wen1, config_type,
              aluresult0, aluresult1, storedata0, storedata1,
              woffset0, woffset1, vl, vtype
    );

    modport execute (
        output load, store, wen0, wen1, config_type,
               aluresult0, aluresult1, storedata0, storedata1,
               woffset0, woffset1, vl, vtype
    );
endinterface

interface rv32v_memory_writeback_if;
    import rv32v_types_pkg::*;

    logic     wen0;
    logic     wen1;
    word_t    wdata0;
    word_t    wdata1;
    woffset_t woffset0;
    woffset_t woffset1;
    logic     config_type;
    vl_t      vl;
    vtype_t   vtype;

    modport memory (
        output wen0, wen1, wdata0, wdata1, woffset0, woffset1,
               config_type, vl, vtype
    );

    modport writeback (
        input wen0, wen1, wdata0, wdata1, woffset0, woffset1,
              config_type, vl, vtype
    );
endinterface

// File: rtl/rv32v_memory_stage_mem_align.sv
// -----------------------------------------------------------------------------
// rv32v_mem_align
// Combinational element-width alignment between a vector element and the
// 32-bit data-memory word.
//   sew        in  : element width
//   addr       in  : byte offset of the element within the word
//   store_data in  : element value to store (right-justified)
//   rdata      in  : raw word returned by data memory
//   byte_en    out : byte lanes touched by the element
//   wdata      out : store data moved into its byte lanes
//   load_data  out : loaded element, right-justified and zero-extended
// -----------------------------------------------------------------------------
module rv32v_mem_align
    import rv32v_types_pkg::*;
(
    input  sew_t        sew,
    input  logic [1:0]  addr,
    input  word_t       store_data,
    input  word_t       rdata,
    output logic [3:0]  byte_en,
    output word_t       wdata,
    output word_t       load_data
);

    logic [4:0] shamt;
    word_t      shifted;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        byte_en = 4'hF;
        shamt   = 5'd0;
        case (sew)
            SEW8: begin
                byte_en = 4'b0001 << addr;
                shamt   = {addr, 3'b000};
            end
            SEW16: begin
                byte_en = 4'b0011 << {addr[1], 1'b0};
                shamt   = {addr[1], 4'b0000};
            end
            default: ;
        endcase
    end

    assign wdata   = store_data << shamt;
    assign shifted = rdata >> shamt;

    always_comb begin
        case (sew)
            SEW8:    load_data = {24'b0, shifted[7:0]};
            SEW16:   load_data = {16'b0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/rv32v_memory_stage.sv
// -----------------------------------------------------------------------------
// rv32v_memory_stage
// Vector pipeline memory stage. Serialises the two per-lane element accesses
// of a vector load/store onto the single data-memory port, aligns data to the
// element width and registers per-lane results into the memory/writeback latch.
//   CLK, nRST           : clock, asynchronous active-low reset
//   hu_if               : stall_mem/flush_mem from hazard unit, mem_busy back
//   execute_memory_if   : incoming execute/memory latch
//   memory_writeback_if : registered memory/writeback latch
//   dmem_ren/dmem_wen   : read/write request, held until !dmem_busy
//   dmem_addr           : word address of the current element
//   dmem_wdata          : lane-shifted store data
//   dmem_byte_en        : byte enables of the current element
//   dmem_rdata          : read data, valid in the cycle dmem_busy is low
//   dmem_busy           : current request not yet complete
// -----------------------------------------------------------------------------
module rv32v_memory_stage
    import rv32v_types_pkg::*;
(
    input  logic                             CLK,
    input  logic                             nRST,
    rv32v_hazard_unit_if.memory              hu_if,
    rv32v_execute_memory_if.memory           execute_memory_if,
    rv32v_memory_writeback_if.memory         memory_writeback_if,
    output logic                             dmem_ren,
    output logic                             dmem_wen,
    output word_t                            dmem_addr,
    output word_t                            dmem_wdata,
    output logic [3:0]                       dmem_byte_en,
    input  word_t                            dmem_rdata,
    input  logic                             dmem_busy
);

    mem_state_t state, next_state;

    logic       ls;
    logic       any_active;
    logic       req;
    logic       req_live;
    logic       sel1;
    logic       busy;
    logic       latch_en;
    sew_t       sew;
    word_t      elem_addr;
    word_t      elem_store;
    word_t      align_wdata;
    word_t      load_data;
    logic [3:0] align_byte_en;
    word_t      buf0;
    word_t      buf1;

    assign ls         = execute_memory_if.load | execute_memory_if.store;
    assign any_active = execute_memory_if.wen0 | execute_memory_if.wen1;
    assign sew        = decode_sew(execute_memory_if.vtype[5:3]);

    // ---------------------------------------------------------------- FSM ---
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The execute/memory latch is held by the hazard unit while mem_busy is
    // high, so its fields stay valid across ELEM1 and DONE.
    always_comb begin
        next_state = state;
        req        = 1'b0;
        sel1       = 1'b0;
        busy       = 1'b0;
        latch_en   = 1'b0;
        case (state)
            IDLE: begin
                if (ls && any_active) begin
                    busy = 1'b1;
                    if (execute_memory_if.wen0) begin
                        req = 1'b1;
                        if (!dmem_busy) begin
                            next_state = execute_memory_if.wen1 ? ELEM1 : DONE;
                        end
                    end else begin
                        // Element 0 masked: spend one cycle moving to element 1.
                        next_state = ELEM1;
                    end
                end else begin
                    latch_en = !hu_if.stall_mem;
                end
            end
            ELEM1: begin
                busy = 1'b1;
                req  = 1'b1;
                sel1 = 1'b1;
                if (!dmem_busy) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (!hu_if.stall_mem) begin
                    latch_en   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (hu_if.flush_mem) begin
            next_state = IDLE;
        end
    end

    // ---------------------------------------------------- element datapath ---
    assign elem_addr  = sel1 ? execute_memory_if.aluresult1 : execute_memory_if.aluresult0;
    assign elem_store = sel1 ? execute_memory_if.storedata1 : execute_memory_if.storedata0;

    rv32v_mem_align u_align (
        .sew        (sew),
        .addr       (elem_addr[1:0]),
        .store_data (elem_store),
        .rdata      (dmem_rdata),
        .byte_en    (align_byte_en),
        .wdata      (align_wdata),
        .load_data  (load_data)
    );

    // NOTE: requests are decoded combinationally from state, so they are
    // qualified with nRST to drop the instant reset asserts rather than
    // waiting for the upstream latch to clear.
    assign req_live      = req & nRST;
    assign dmem_ren      = req_live & execute_memory_if.load;
    assign dmem_wen      = req_live & execute_memory_if.store;
    assign dmem_addr     = req_live ? {elem_addr[31:2], 2'b00} : '0;
    assign dmem_wdata    = req_live ? align_wdata : '0;
    assign dmem_byte_en  = req_live ? align_byte_en : 4'b0000;
    assign hu_if.mem_busy = busy & nRST;

    // ------------------------------------------------------- load buffers ---
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            buf0 <= '0;
            buf1 <= '0;
        end else if (req && !dmem_busy) begin
            if (sel1) begin
                buf1 <= load_data;
            end else begin
                buf0 <= load_data;
            end
        end
    end

    // --------------------------------------------- memory/writeback latch ---
    // Loads return the buffered element (0 for a masked element); everything
    // else forwards the ALU result. Stores never write back a register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            memory_writeback_if.wen0        <= 1'b0;
            memory_writeback_if.wen1        <= 1'b0;
            memory_writeback_if.wdata0      <= '0;
            memory_writeback_if.wdata1      <= '0;
            memory_writeback_if.woffset0    <= '0;
            memory_writeback_if.woffset1    <= '0;
            memory_writeback_if.config_type <= 1'b0;
            memory_writeback_if.vl          <= '0;
            memory_writeback_if.vtype       <= '0;
        end else if (hu_if.flush_mem) begin
            memory_writeback_if.wen0        <= 1'b0;
            memory_writeback_if.wen1        <= 1'b0;
            memory_writeback_if.wdata0      <= '0;
            memory_writeback_if.wdata1      <= '0;
            memory_writeback_if.woffset0    <= '0;
            memory_writeback_if.woffset1    <= '0;
            memory_writeback_if.config_type <= 1'b0;
            memory_writeback_if.vl          <= '0;
            memory_writeback_if.vtype       <= '0;
        end else if (latch_en) begin
            memory_writeback_if.wen0        <= execute_memory_if.wen0 & ~execute_memory_if.store;
            memory_writeback_if.wen1        <= execute_memory_if.wen1 & ~execute_memory_if.store;
            memory_writeback_if.wdata0      <= execute_memory_if.load
                                             ? (execute_memory_if.wen0 ? buf0 : '0)
                                             : execute_memory_if.aluresult0;
            memory_writeback_if.wdata1      <= execute_memory_if.load
                                             ? (execute_memory_if.wen1 ? buf1 : '0)
                                             : execute_memory_if.aluresult1;
            memory_writeback_if.woffset0    <= execute_memory_if.woffset0;
            memory_writeback_if.woffset1    <= execute_memory_if.woffset1;
            memory_writeback_if.config_type <= execute_memory_if.config_type;
            memory_writeback_if.vl          <= execute_memory_if.vl;
            memory_writeback_if.vtype       <= execute_memory_if.vtype;
        end
    end

endmodule

// File: tb/tb_rv32v_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_rv32v_memory_stage
// Directed self-checking bench for rv32v_memory_stage. Expected latch contents
// are queued when an operation is driven and popped when the latch captures.
// -----------------------------------------------------------------------------
module tb_rv32v_memory_stage;
    import rv32v_types_pkg::*;

    logic       CLK;
    logic       nRST;
    logic       dmem_ren;
    logic       dmem_wen;
    word_t      dmem_addr;
    word_t      dmem_wdata;
    logic [3:0] dmem_byte_en;
    word_t      dmem_rdata;
    logic       dmem_busy;

    rv32v_hazard_unit_if      hu ();
    rv32v_execute_memory_if   em ();
    rv32v_memory_writeback_if mw ();

    rv32v_memory_stage dut (
        .CLK                 (CLK),
        .nRST                (nRST),
        .hu_if               (hu),
        .execute_memory_if   (em),
        .memory_writeback_if (mw),
        .dmem_ren            (dmem_ren),
        .dmem_wen            (dmem_wen),
        .dmem_addr           (dmem_addr),
        .dmem_wdata          (dmem_wdata),
        .dmem_byte_en        (dmem_byte_en),
        .dmem_rdata          (dmem_rdata),
        .dmem_busy           (dmem_busy)
    );

    typedef struct {
        logic     wen0;
        logic     wen1;
        word_t    wdata0;
        word_t    wdata1;
        woffset_t woffset0;
        woffset_t woffset1;
        logic     config_type;
        vl_t      vl;
        vtype_t   vtype;
    } lat_t;

    lat_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic w0, input logic w1,
                            input logic [31:0] vt, input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] s0, input logic [31:0] s1, input logic cfg,
                            input logic [4:0] wo0, input logic [4:0] wo1, input logic [31:0] vlen);
        em.load        = ld;
        em.store       = st;
        em.wen0        = w0;
        em.wen1        = w1;
        em.vtype       = vt;
        em.aluresult0  = a0;
        em.aluresult1  = a1;
        em.storedata0  = s0;
        em.storedata1  = s1;
        em.config_type = cfg;
        em.woffset0    = wo0;
        em.woffset1    = wo1;
        em.vl          = vlen;
    endtask

    task automatic bubble();
        drive_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0);
    endtask

    // Expected record from the values the bench is currently driving.
    task automatic push_exp(input logic w0, input logic w1, input word_t d0, input word_t d1);
        lat_t e;
        e.wen0        = w0;
        e.wen1        = w1;
        e.wdata0      = d0;
        e.wdata1      = d1;
        e.woffset0    = em.woffset0;
        e.woffset1    = em.woffset1;
        e.config_type = em.config_type;
        e.vl          = em.vl;
        e.vtype       = em.vtype;
        exp_q.push_back(e);
    endtask

    task automatic push_zero();
        lat_t e;
        e.wen0 = 1'b0; e.wen1 = 1'b0; e.wdata0 = '0; e.wdata1 = '0;
        e.woffset0 = '0; e.woffset1 = '0; e.config_type = 1'b0; e.vl = '0; e.vtype = '0;
        exp_q.push_back(e);
    endtask

    task automatic check_latch(input string tag);
        lat_t e;
        check({tag, "_queued"}, {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_wen"}, {30'b0, mw.wen1, mw.wen0}, {30'b0, e.wen1, e.wen0});
            check({tag, "_wdata0"}, mw.wdata0, e.wdata0);
            check({tag, "_wdata1"}, mw.wdata1, e.wdata1);
            check({tag, "_side"}, {21'b0, mw.woffset0, mw.woffset1, mw.config_type},
                                  {21'b0, e.woffset0, e.woffset1, e.config_type});
            check({tag, "_vl"}, mw.vl, e.vl);
            check({tag, "_vtype"}, mw.vtype, e.vtype);
        end
    endtask

    initial begin
        int cnt;

        nRST = 1'b0;
        hu.stall_mem = 1'b0;
        hu.flush_mem = 1'b0;
        dmem_busy  = 1'b0;
        dmem_rdata = 32'h0;
        bubble();

        // ---- reset state
        #12;
        check("rst_busy", {31'b0, hu.mem_busy}, 32'd0);
        check("rst_ren", {31'b0, dmem_ren}, 32'd0);
        check("rst_wen", {31'b0, dmem_wen}, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_be", {28'b0, dmem_byte_en}, 32'd0);
        check("rst_latch_wen", {30'b0, mw.wen1, mw.wen0}, 32'd0);
        check("rst_latch_wdata0", mw.wdata0, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        step();

        // ---- ALU op: one-cycle pass-through, no memory traffic
        drive_op(1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h11, 32'h22, 32'h0, 32'h0, 1'b1, 5'd1, 5'd2, 32'd2);
        push_exp(1'b1, 1'b1, 32'h11, 32'h22);
        mid();
        check("alu_busy", {31'b0, hu.mem_busy}, 32'd0);
        check("alu_ren", {31'b0, dmem_ren}, 32'd0);
        check("alu_wen", {31'b0, dmem_wen}, 32'd0);
        step();
        check_latch("alu");

        // ---- SEW32 load, two active elements, zero wait
        drive_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h100, 32'h104, 32'h0, 32'h0, 1'b0, 5'd3, 5'd4, 32'd4);
        dmem_rdata = 32'hAAAA5555;
        push_exp(1'b1, 1'b1, 32'hAAAA5555, 32'h12345678);
        mid();
        check("ld32_e0_busy", {31'b0, hu.mem_busy}, 32'd1);
        check("ld32_e0_ren", {31'b0, dmem_ren}, 32'd1);
        check("ld32_e0_addr", dmem_addr, 32'h100);
        check("ld32_e0_be", {28'b0, dmem_byte_en}, 32'hF);
        step();
        dmem_rdata = 32'h12345678;
        mid();
        check("ld32_e1_busy", {31'b0, hu.mem_busy}, 32'd1);
        check("ld32_e1_ren", {31'b0, dmem_ren}, 32'd1);
        check("ld32_e1_addr", dmem_addr, 32'h104);
        step();
        mid();
        check("ld32_done_busy", {31'b0, hu.mem_busy}, 32'd0);
        check("ld32_done_ren", {31'b0, dmem_ren}, 32'd0);
        check("ld32_done_old_latch", mw.wdata0, 32'h11);
        step();
        bubble();
        check_latch("ld32");

        // ---- SEW8 store to byte 3
        drive_op(1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 32'h203, 32'h55, 32'hEF, 32'h0, 1'b0, 5'd5, 5'd6, 32'd1);
        push_exp(1'b0, 1'b0, 32'h203, 32'h55);
        mid();
        check("st8_busy", {31'b0, hu.mem_busy}, 32'd1);
        check("st8_wen", {31'b0, dmem_wen}, 32'd1);
        check("st8_ren", {31'b0, dmem_ren}, 32'd0);
        check("st8_addr", dmem_addr, 32'h200);
        check("st8_be", {28'b0, dmem_byte_en}, 32'h8);
        check("st8_wdata", dmem_wdata, 32'hEF000000);
        step();
        mid();
        check("st8_done_busy", {31'b0, hu.mem_busy}, 32'd0);
        check("st8_done_wen", {31'b0, dmem_wen}, 32'd0);
        step();
        bubble();
        check_latch("st8");

        // ---- SEW16 load, upper half, element 1 masked, three wait cycles
        drive_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h08, 32'h102, 32'h999, 32'h0, 32'h0, 1'b1, 5'd7, 5'd8, 32'd3);
        dmem_rdata = 32'hBEEF0000;
        dmem_busy  = 1'b1;
        push_exp(1'b1, 1'b0, 32'h0000BEEF, 32'h0);
        cnt = 0;
        while (cnt < 20) begin
            mid();
            if (!hu.mem_busy) break;
            cnt++;
            check("ld16_addr", dmem_addr, 32'h100);
            check("ld16_be", {28'b0, dmem_byte_en}, 32'hC);
            step();
            dmem_busy = (cnt < 3);
        end
        check("ld16_busy_cycles", cnt, 32'd4);
        check("ld16_done_ren", {31'b0, dmem_ren}, 32'd0);
        step();
        bubble();
        check_latch("ld16");

        // ---- element 0 masked, stall for two cycles in DONE
        drive_op(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h500, 32'h108, 32'h0, 32'h0, 1'b0, 5'd9, 5'd10, 32'd5);
        dmem_rdata = 32'hCAFEF00D;
        push_exp(1'b0, 1'b1, 32'h0, 32'hCAFEF00D);
        mid();
        check("skip_busy", {31'b0, hu.mem_busy}, 32'd1);
        check("skip_ren", {31'b0, dmem_ren}, 32'd0);
        step();
        mid();
        check("skip_e1_ren", {31'b0, dmem_ren}, 32'd1);
        check("skip_e1_addr", dmem_addr, 32'h108);
        step();
        hu.stall_mem = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mid();
            check("stall_busy", {31'b0, hu.mem_busy}, 32'd0);
            check("stall_latch_held", mw.wdata0, 32'h0000BEEF);
            step();
        end
        hu.stall_mem = 1'b0;
        mid();
        check("stall_release_busy", {31'b0, hu.mem_busy}, 32'd0);
        step();
        bubble();
        check_latch("stall");

        // ---- flush during ELEM1 of a load
        drive_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h300, 32'h304, 32'h0, 32'h0, 1'b1, 5'd11, 5'd12, 32'd6);
        dmem_rdata = 32'h0F0F0F0F;
        mid();
        check("flush_e0_ren", {31'b0, dmem_ren}, 32'd1);
        step();
        dmem_busy    = 1'b1;
        hu.flush_mem = 1'b1;
        mid();
        check("flush_e1_ren", {31'b0, dmem_ren}, 32'd1);
        check("flush_e1_addr", dmem_addr, 32'h304);
        step();
        hu.flush_mem = 1'b0;
        dmem_busy    = 1'b0;
        bubble();
        push_zero();
        check_latch("flush");
        mid();
        check("flush_after_ren", {31'b0, dmem_ren}, 32'd0);
        check("flush_after_busy", {31'b0, hu.mem_busy}, 32'd0);
        step();
        drive_op(1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h77, 32'h88, 32'h0, 32'h0, 1'b0, 5'd13, 5'd14, 32'd7);
        push_exp(1'b1, 1'b1, 32'h77, 32'h88);
        step();
        check_latch("post_flush");

        // ---- asynchronous reset in the middle of a store access
        drive_op(1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h400, 32'h404, 32'h1234, 32'h5678, 1'b0, 5'd15, 5'd16, 32'd8);
        dmem_busy = 1'b1;
        mid();
        check("arst_pre_wen", {31'b0, dmem_wen}, 32'd1);
        #1;
        nRST = 1'b0;
        #1;
        check("arst_wen", {31'b0, dmem_wen}, 32'd0);
        check("arst_busy", {31'b0, hu.mem_busy}, 32'd0);
        check("arst_addr", dmem_addr, 32'd0);
        check("arst_latch_wdata0", mw.wdata0, 32'd0);
        bubble();
        dmem_busy = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        step();
        mid();
        check("arst_after_busy", {31'b0, hu.mem_busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
